// File: rtl/board_draw_sched.sv
// board_draw_sched
//   Owns the single 24x24 box-drawing engine and shares it between a full-board
//   redraw (raster walk of the board RAM, one box per cell) and single-cell draws
//   issued by game logic. Converts (col,row) to the pixel origin of the cell and
//   runs the engine through its start/done handshake. While a redraw is active,
//   redraw boxes and cell boxes alternate so neither requester starves.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   frame_req_i    1-cycle pulse: request a full-board redraw
//   cell_req_i     level: single-cell draw request, held until cell_ack_o
//   cell_col_i     column of requested cell
//   cell_row_i     row of requested cell
//   cell_color_i   RRR_GGG_BBB colour of requested cell
//   cell_ack_o     1-cycle pulse: requested cell fully drawn
//   board_addr_o   board RAM read address (row*COLS+col)
//   board_rdata_i  board RAM data, valid the cycle after board_addr_o
//   box_start_o    1-cycle start pulse to the box engine
//   box_x0_o       box top-left X, held from box_start_o until box_done_i
//   box_y0_o       box top-left Y, held from box_start_o until box_done_i
//   box_color_o    box colour, held from box_start_o until box_done_i
//   box_done_i     1-cycle pulse from the engine: box finished
//   busy_o         high in every state except idle
//   frame_done_o   1-cycle pulse: last box of a full redraw finished

module board_draw_sched #(
    parameter int unsigned COLS     = 10,
    parameter int unsigned ROWS     = 20,
    parameter int unsigned CELL     = 24,
    parameter int unsigned X_ORIGIN = 200,
    parameter int unsigned Y_ORIGIN = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       frame_req_i,
    input  logic       cell_req_i,
    input  logic [3:0] cell_col_i,
    input  logic [4:0] cell_row_i,
    input  logic [8:0] cell_color_i,
    output logic       cell_ack_o,
    output logic [7:0] board_addr_o,
    input  logic [8:0] board_rdata_i,
    output logic       box_start_o,
    output logic [9:0] box_x0_o,
    output logic [8:0] box_y0_o,
    output logic [8:0] box_color_o,
    input  logic       box_done_i,
    output logic       busy_o,
    output logic       frame_done_o
);

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StFetch,
        StLoad,
        StStart,
        StWait,
        StCack,
        StFadv
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic       frame_pend_q, frame_pend_d;
    logic       frame_active_q, frame_active_d;
    logic       turn_q, turn_d;          // 1: a frame box is owed before the next cell box
    logic       job_cell_q, job_cell_d;  // job currently on the engine is a cell draw
    logic [9:0] box_x0_q, box_x0_d;
    logic [8:0] box_y0_q, box_y0_d;
    logic [8:0] box_color_q, box_color_d;

    logic [9:0] cell_x;
    logic [8:0] cell_y;
    logic [9:0] frame_x;
    logic [8:0] frame_y;
    logic       last_cell;
    logic       last_col;

    // Pixel origins, truncated to port width (out-of-range coords draw as computed).
    assign cell_x  = 10'(X_ORIGIN + 32'(cell_col_i) * CELL);
    assign cell_y  = 9'(Y_ORIGIN + 32'(cell_row_i) * CELL);
    assign frame_x = 10'(X_ORIGIN + 32'(col_q) * CELL);
    assign frame_y = 9'(Y_ORIGIN + 32'(row_q) * CELL);

    assign last_col  = (32'(col_q) == COLS - 1);
    assign last_cell = last_col && (32'(row_q) == ROWS - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            col_q          <= '0;
            row_q          <= '0;
            frame_pend_q   <= 1'b0;
            frame_active_q <= 1'b0;
            turn_q         <= 1'b0;
            job_cell_q     <= 1'b0;
            box_x0_q       <= '0;
            box_y0_q       <= '0;
            box_color_q    <= '0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            frame_pend_q   <= frame_pend_d;
            frame_active_q <= frame_active_d;
            turn_q         <= turn_d;
            job_cell_q     <= job_cell_d;
            box_x0_q       <= box_x0_d;
            box_y0_q       <= box_y0_d;
            box_color_q    <= box_color_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        // A new request is never lost, even on the cycle a pending frame is consumed.
        frame_pend_d   = frame_pend_q | frame_req_i;
        frame_active_d = frame_active_q;
        turn_d         = turn_q;
        job_cell_d     = job_cell_q;
        box_x0_d       = box_x0_q;
        box_y0_d       = box_y0_q;
        box_color_d    = box_color_q;

        case (state_q)
            StIdle, StArb: begin
                if (cell_req_i && (!turn_q || !frame_active_q)) begin
                    box_x0_d    = cell_x;
                    box_y0_d    = cell_y;
                    box_color_d = cell_color_i;
                    job_cell_d  = 1'b1;
                    state_d     = StStart;
                end else if (frame_active_q) begin
                    job_cell_d = 1'b0;
                    state_d    = StFetch;
                end else if (frame_pend_q) begin
                    col_d          = '0;
                    row_d          = '0;
                    frame_active_d = 1'b1;
                    frame_pend_d   = frame_req_i;
                    job_cell_d     = 1'b0;
                    state_d        = StFetch;
                end else if (frame_req_i) begin
                    // Pend is being set this edge; arbitrate it next cycle.
                    state_d = StArb;
                end else begin
                    state_d = StIdle;
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                box_color_d = board_rdata_i;
                box_x0_d    = frame_x;
                box_y0_d    = frame_y;
                state_d     = StStart;
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (box_done_i) begin
                    state_d = job_cell_q ? StCack : StFadv;
                end
            end
            StCack: begin
                turn_d  = 1'b1;
                state_d = StArb;
            end
            StFadv: begin
                turn_d = 1'b0;
                if (last_cell) begin
                    frame_active_d = 1'b0;
                    col_d          = '0;
                    row_d          = '0;
                end else if (last_col) begin
                    col_d = '0;
                    row_d = row_q + 5'd1;
                end else begin
                    col_d = col_q + 4'd1;
                end
                state_d = StArb;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign board_addr_o = 8'(32'(row_q) * COLS + 32'(col_q));
    assign box_start_o  = (state_q == StStart);
    assign cell_ack_o   = (state_q == StCack);
    assign frame_done_o = (state_q == StFadv) && last_cell;
    assign busy_o       = (state_q != StIdle);
    assign box_x0_o     = box_x0_q;
    assign box_y0_o     = box_y0_q;
    assign box_color_o  = box_color_q;

endmodule

// File: tb/tb_board_draw_sched.sv
// tb_board_draw_sched
//   Bench for board_draw_sched. A box-engine model answers each box_start with
//   box_done a fixed number of cycles later; a board RAM model returns data equal
//   to its address one cycle after the address. Expected boxes are queued when
//   stimulus is driven and compared against the boxes the DUT actually starts.

module tb_board_draw_sched;

    localparam int LAT = 2;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [8:0] c;
    } box_t;

    logic       clk;
    logic       rst_n;
    logic       frame_req;
    logic       cell_req;
    logic [3:0] cell_col;
    logic [4:0] cell_row;
    logic [8:0] cell_color;
    logic       cell_ack;
    logic [7:0] board_addr;
    logic [8:0] board_rdata;
    logic       box_start;
    logic [9:0] box_x0;
    logic [8:0] box_y0;
    logic [8:0] box_color;
    logic       box_done;
    logic       busy;
    logic       frame_done;

    box_t exp_q[$];
    box_t obs_q[$];

    int   cyc;
    int   n_start;
    int   n_ack;
    int   n_fdone;
    int   start_cyc;
    int   ack_cyc;
    int   done_cyc;
    int   eng_cnt;
    logic eng_done;
    logic [7:0] prev_addr;
    int   n_assert;
    int   n_fail;

    board_draw_sched dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .frame_req_i   (frame_req),
        .cell_req_i    (cell_req),
        .cell_col_i    (cell_col),
        .cell_row_i    (cell_row),
        .cell_color_i  (cell_color),
        .cell_ack_o    (cell_ack),
        .board_addr_o  (board_addr),
        .board_rdata_i (board_rdata),
        .box_start_o   (box_start),
        .box_x0_o      (box_x0),
        .box_y0_o      (box_y0),
        .box_color_o   (box_color),
        .box_done_i    (box_done),
        .busy_o        (busy),
        .frame_done_o  (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic box_t frame_box(int a);
        box_t b;
        b.x = 10'(200 + (a % 10) * 24);
        b.y = 9'((a / 10) * 24);
        b.c = 9'(a);
        return b;
    endfunction

    // Advance to the next falling edge, record DUT outputs, update RAM and engine models.
    task automatic tick();
        box_t b;
        @(negedge clk);
        cyc++;
        if (box_start) begin
            b.x = box_x0;
            b.y = box_y0;
            b.c = box_color;
            obs_q.push_back(b);
            n_start++;
            start_cyc = cyc;
        end
        if (cell_ack) begin
            n_ack++;
            ack_cyc = cyc;
        end
        if (frame_done) n_fdone++;
        board_rdata = 9'(prev_addr);
        prev_addr   = board_addr;
        eng_done = 1'b0;
        if (!rst_n) begin
            eng_cnt = 0;
        end else if (eng_cnt != 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done = 1'b1;
                done_cyc = cyc;
            end
        end else if (box_start) begin
            eng_cnt = LAT;
        end
        box_done = eng_done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b, expected 0", busy);
        end
        n_assert++;
        if ({box_start, cell_ack, frame_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b, expected 000", {box_start, cell_ack, frame_done});
        end
        n_assert++;
        if ({box_x0, box_y0, box_color} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_box_regs: got x0=%0d y0=%0d color=%h, expected 0",
                     box_x0, box_y0, box_color);
        end
        n_assert++;
        if (board_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d, expected 0", board_addr);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_cell();
        int   req_cyc;
        int   a0;
        box_t e;
        box_t o;
        exp_q.delete();
        obs_q.delete();
        e.x = 10'd272;
        e.y = 9'd120;
        e.c = 9'h1C0;
        exp_q.push_back(e);
        a0 = n_ack;
        cell_col   = 4'd3;
        cell_row   = 5'd5;
        cell_color = 9'h1C0;
        cell_req   = 1'b1;
        req_cyc    = cyc;
        for (int i = 0; i < 50 && n_ack == a0; i++) tick();
        cell_req = 1'b0;
        n_assert++;
        if (n_ack != a0 + 1) begin
            n_fail++;
            $display("FAIL cell_ack_count: got %0d, expected 1", n_ack - a0);
        end
        n_assert++;
        if (start_cyc != req_cyc + 1) begin
            n_fail++;
            $display("FAIL cell_latency: got %0d cycles, expected 1", start_cyc - req_cyc);
        end
        n_assert++;
        if (ack_cyc != done_cyc + 1) begin
            n_fail++;
            $display("FAIL cell_ack_timing: got %0d cycles after done, expected 1",
                     ack_cyc - done_cyc);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL cell_box: got none, expected x0=%0d y0=%0d color=%h", e.x, e.y, e.c);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL cell_box: got x0=%0d y0=%0d color=%h, expected x0=%0d y0=%0d color=%h",
                             o.x, o.y, o.c, e.x, e.y, e.c);
                end
            end
        end
        n_assert++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL cell_extra_boxes: got %0d, expected 0", obs_q.size());
        end
        repeat (5) tick();
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cell_idle_after: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_frame();
        int   req_cyc;
        int   s0;
        int   f0;
        box_t e;
        box_t o;
        exp_q.delete();
        obs_q.delete();
        for (int a = 0; a < 200; a++) exp_q.push_back(frame_box(a));
        s0 = n_start;
        f0 = n_fdone;
        frame_req = 1'b1;
        req_cyc   = cyc;
        tick();
        frame_req = 1'b0;
        for (int i = 0; i < 20 && n_start == s0; i++) tick();
        n_assert++;
        if (start_cyc != req_cyc + 4) begin
            n_fail++;
            $display("FAIL frame_latency: got %0d cycles, expected 4", start_cyc - req_cyc);
        end
        for (int i = 0; i < 4000 && n_fdone == f0; i++) tick();
        repeat (20) tick();
        n_assert++;
        if (n_fdone != f0 + 1) begin
            n_fail++;
            $display("FAIL frame_done_count: got %0d, expected 1", n_fdone - f0);
        end
        n_assert++;
        if (n_start != s0 + 200) begin
            n_fail++;
            $display("FAIL frame_box_count: got %0d, expected 200", n_start - s0);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL frame_box: got none, expected x0=%0d y0=%0d color=%h", e.x, e.y, e.c);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL frame_box: got x0=%0d y0=%0d color=%h, expected x0=%0d y0=%0d color=%h",
                             o.x, o.y, o.c, e.x, e.y, e.c);
                end
            end
        end
        obs_q.delete();
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_idle_after: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_fairness();
        int   s0;
        int   f0;
        int   a0;
        bit   raised;
        box_t e;
        box_t o;
        exp_q.delete();
        obs_q.delete();
        for (int a = 0; a <= 50; a++) exp_q.push_back(frame_box(a));
        e.x = 10'd368;
        e.y = 9'd48;
        e.c = 9'h0AA;
        exp_q.push_back(e);
        for (int a = 51; a < 200; a++) exp_q.push_back(frame_box(a));
        s0 = n_start;
        f0 = n_fdone;
        a0 = n_ack;
        raised = 1'b0;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        for (int i = 0; i < 5000 && n_fdone == f0; i++) begin
            tick();
            if (!raised && n_start - s0 == 51) begin
                cell_col   = 4'd7;
                cell_row   = 5'd2;
                cell_color = 9'h0AA;
                cell_req   = 1'b1;
                raised     = 1'b1;
            end
            if (cell_req && n_ack != a0) cell_req = 1'b0;
        end
        cell_req = 1'b0;
        repeat (10) tick();
        n_assert++;
        if (n_ack != a0 + 1) begin
            n_fail++;
            $display("FAIL fair_ack_count: got %0d, expected 1", n_ack - a0);
        end
        n_assert++;
        if (n_start != s0 + 201) begin
            n_fail++;
            $display("FAIL fair_box_count: got %0d, expected 201", n_start - s0);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL fair_box: got none, expected x0=%0d y0=%0d color=%h", e.x, e.y, e.c);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL fair_box: got x0=%0d y0=%0d color=%h, expected x0=%0d y0=%0d color=%h",
                             o.x, o.y, o.c, e.x, e.y, e.c);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_frame_pend();
        int       s0;
        int       f0;
        int       d;
        bit [2:0] pulsed;
        box_t     e;
        box_t     o;
        exp_q.delete();
        obs_q.delete();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 200; a++) exp_q.push_back(frame_box(a));
        s0 = n_start;
        f0 = n_fdone;
        pulsed = 3'b000;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        for (int i = 0; i < 8000 && n_fdone - f0 < 2; i++) begin
            tick();
            d = n_start - s0;
            frame_req = 1'b0;
            if (d == 20 && !pulsed[0]) begin
                frame_req = 1'b1;
                pulsed[0] = 1'b1;
            end else if (d == 60 && !pulsed[1]) begin
                frame_req = 1'b1;
                pulsed[1] = 1'b1;
            end else if (d == 100 && !pulsed[2]) begin
                frame_req = 1'b1;
                pulsed[2] = 1'b1;
            end
        end
        frame_req = 1'b0;
        repeat (30) tick();
        n_assert++;
        if (n_fdone != f0 + 2) begin
            n_fail++;
            $display("FAIL pend_done_count: got %0d, expected 2", n_fdone - f0);
        end
        n_assert++;
        if (n_start != s0 + 400) begin
            n_fail++;
            $display("FAIL pend_box_count: got %0d, expected 400", n_start - s0);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL pend_box: got none, expected x0=%0d y0=%0d color=%h", e.x, e.y, e.c);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL pend_box: got x0=%0d y0=%0d color=%h, expected x0=%0d y0=%0d color=%h",
                             o.x, o.y, o.c, e.x, e.y, e.c);
                end
            end
        end
        obs_q.delete();
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_idle_after: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int   s0;
        int   f0;
        int   a0;
        box_t e;
        box_t o;
        exp_q.delete();
        obs_q.delete();
        for (int a = 0; a <= 12; a++) exp_q.push_back(frame_box(a));
        s0 = n_start;
        f0 = n_fdone;
        a0 = n_ack;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        for (int i = 0; i < 500 && n_start - s0 < 13; i++) tick();
        tick();  // now waiting on the engine for cell 12
        rst_n = 1'b0;
        #1;
        n_assert++;
        if ({box_x0, box_y0, box_color} !== 28'd0) begin
            n_fail++;
            $display("FAIL midreset_box_regs: got x0=%0d y0=%0d color=%h, expected 0",
                     box_x0, box_y0, box_color);
        end
        n_assert++;
        if ({busy, box_start, cell_ack, frame_done, board_addr} !== 12'd0) begin
            n_fail++;
            $display("FAIL midreset_ctrl: got busy=%b start=%b ack=%b fdone=%b addr=%0d, expected 0",
                     busy, box_start, cell_ack, frame_done, board_addr);
        end
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        n_assert++;
        if (n_ack != a0 || n_fdone != f0) begin
            n_fail++;
            $display("FAIL midreset_no_pulses: got ack=%0d fdone=%0d, expected 0 0",
                     n_ack - a0, n_fdone - f0);
        end
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: got busy=%b, expected 0", busy);
        end
        for (int a = 0; a < 200; a++) exp_q.push_back(frame_box(a));
        f0 = n_fdone;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        for (int i = 0; i < 4000 && n_fdone == f0; i++) tick();
        repeat (10) tick();
        n_assert++;
        if (n_fdone != f0 + 1) begin
            n_fail++;
            $display("FAIL midreset_restart_done: got %0d, expected 1", n_fdone - f0);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL midreset_box: got none, expected x0=%0d y0=%0d color=%h", e.x, e.y, e.c);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL midreset_box: got x0=%0d y0=%0d color=%h, expected x0=%0d y0=%0d color=%h",
                             o.x, o.y, o.c, e.x, e.y, e.c);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_spurious_done();
        int   s0;
        int   a0;
        box_t e;
        box_t o;
        exp_q.delete();
        obs_q.delete();
        s0 = n_start;
        a0 = n_ack;
        box_done = 1'b1;  // in idle
        tick();
        repeat (3) tick();
        n_assert++;
        if (busy !== 1'b0 || n_start != s0 || n_ack != a0) begin
            n_fail++;
            $display("FAIL spur_idle: got busy=%b starts=%0d acks=%0d, expected 0 0 0",
                     busy, n_start - s0, n_ack - a0);
        end
        e.x = 10'd200;
        e.y = 9'd0;
        e.c = 9'h007;
        exp_q.push_back(e);
        cell_col   = 4'd0;
        cell_row   = 5'd0;
        cell_color = 9'h007;
        cell_req   = 1'b1;
        for (int i = 0; i < 10 && n_start == s0; i++) tick();
        box_done = 1'b1;  // while in START
        for (int i = 0; i < 50 && n_ack == a0; i++) tick();
        cell_req = 1'b0;
        repeat (5) tick();
        n_assert++;
        if (n_ack != a0 + 1) begin
            n_fail++;
            $display("FAIL spur_ack_count: got %0d, expected 1", n_ack - a0);
        end
        n_assert++;
        if (ack_cyc != done_cyc + 1) begin
            n_fail++;
            $display("FAIL spur_ack_timing: got %0d cycles after engine done, expected 1",
                     ack_cyc - done_cyc);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL spur_box: got none, expected x0=%0d y0=%0d color=%h", e.x, e.y, e.c);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL spur_box: got x0=%0d y0=%0d color=%h, expected x0=%0d y0=%0d color=%h",
                             o.x, o.y, o.c, e.x, e.y, e.c);
                end
            end
        end
        n_assert++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_after: got extra=%0d busy=%b, expected 0 0", obs_q.size(), busy);
        end
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        cyc         = 0;
        n_start     = 0;
        n_ack       = 0;
        n_fdone     = 0;
        start_cyc   = 0;
        ack_cyc     = 0;
        done_cyc    = 0;
        eng_cnt     = 0;
        eng_done    = 1'b0;
        prev_addr   = 8'd0;
        rst_n       = 1'b0;
        frame_req   = 1'b0;
        cell_req    = 1'b0;
        cell_col    = 4'd0;
        cell_row    = 5'd0;
        cell_color  = 9'd0;
        board_rdata = 9'd0;
        box_done    = 1'b0;

        test_reset();
        test_cell();
        test_frame();
        test_fairness();
        test_frame_pend();
        test_reset_mid();
        test_spurious_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
